// File: rtl/i2c_seq_ctrl_if.sv
// Command/response bus between the I2C sequencer and the I2C byte core.
// master = sequencer side, slave = core side.
interface i2c_seq_ctrl_if;
    logic       data_valid;
    logic       rw;
    logic [6:0] slave_addr;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       core_busy;
    logic       core_nack;
    logic [7:0] core_rdata;

    modport master (
        output data_valid, rw, slave_addr, reg_addr, reg_data,
        input  core_busy, core_nack, core_rdata
    );

    modport slave (
        input  data_valid, rw, slave_addr, reg_addr, reg_data,
        output core_busy, core_nack, core_rdata
    );
endinterface

// File: rtl/i2c_seq_ctrl.sv
// Runs a small table of I2C register commands through an I2C core, with
// per-entry NACK retry, a busy-rise timeout, read-result strobes and status.
module i2c_seq_ctrl #(
    parameter int unsigned N_CMD     = 4,
    parameter int unsigned RETRY_MAX = 2,
    parameter int unsigned TMO       = 255,
    parameter int unsigned IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W:0]    num_cmds,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_idx,
    input  logic [23:0]       tbl_wdata,
    i2c_seq_ctrl_if.master    bus,
    output logic              rd_valid,
    output logic [IDX_W-1:0]  rd_idx,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  err_idx
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int unsigned TMO_W = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, CHECK, FINISH} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [IDX_W:0]     num_q, num_n;
    logic [RTY_W-1:0]   rty, rty_n;
    logic [TMO_W-1:0]   tmo, tmo_n;
    logic               nack_q, nack_n;
    logic [7:0]         rdat_q, rdat_n;
    logic               bad, bad_n;
    logic               dv_n, rw_n;
    logic [6:0]         sa_n;
    logic [7:0]         ra_n, rg_n;
    logic               rdv_n;
    logic [IDX_W-1:0]   rdi_n;
    logic [7:0]         rdd_n;
    logic               done_n, err_n;
    logic [IDX_W-1:0]   eidx_n;
    logic [23:0]        entry;
    logic               num_ok, last;

    // Array is sized to the full index space so reads never need a range check;
    // only entries below N_CMD are ever written.
    logic [23:0] tbl [DEPTH];

    // Table storage is deliberately outside reset.
    always_ff @(posedge clk) begin
        if (tbl_we && state == IDLE && 32'(tbl_idx) < N_CMD)
            tbl[tbl_idx] <= tbl_wdata;
    end

    assign num_ok = (num_cmds != '0) && (32'(num_cmds) <= N_CMD);
    assign last   = ({1'b0, idx} == num_q - (IDX_W+1)'(1));

    always_comb begin
        state_n = state;
        idx_n   = idx;
        num_n   = num_q;
        rty_n   = rty;
        tmo_n   = tmo;
        nack_n  = nack_q;
        rdat_n  = rdat_q;
        bad_n   = 1'b0;
        dv_n    = 1'b0;
        rw_n    = bus.rw;
        sa_n    = bus.slave_addr;
        ra_n    = bus.reg_addr;
        rg_n    = bus.reg_data;
        rdv_n   = 1'b0;
        rdi_n   = rd_idx;
        rdd_n   = rd_data;
        done_n  = 1'b0;
        err_n   = error;
        eidx_n  = err_idx;
        entry   = tbl[idx];

        case (state)
            IDLE: begin
                // A rejected start reports error for a single cycle only.
                if (bad) err_n = 1'b0;
                if (start) begin
                    if (num_ok) begin
                        state_n = ISSUE;
                        idx_n   = '0;
                        rty_n   = '0;
                        num_n   = num_cmds;
                        err_n   = 1'b0;
                        eidx_n  = '0;
                    end else begin
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                        eidx_n  = '0;
                        bad_n   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!bus.core_busy) begin
                    dv_n    = 1'b1;
                    rw_n    = entry[23];
                    sa_n    = entry[22:16];
                    ra_n    = entry[15:8];
                    rg_n    = entry[7:0];
                    tmo_n   = '0;
                    state_n = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.core_busy) begin
                    state_n = WAIT_LO;
                end else if (tmo == TMO_W'(TMO - 1)) begin
                    nack_n  = 1'b1;
                    rdat_n  = '0;
                    state_n = CHECK;
                end else begin
                    tmo_n   = tmo + TMO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!bus.core_busy) begin
                    nack_n  = bus.core_nack;
                    rdat_n  = bus.core_rdata;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (!nack_q) begin
                    if (!bus.rw) begin
                        rdv_n = 1'b1;
                        rdi_n = idx;
                        rdd_n = rdat_q;
                    end
                    rty_n   = '0;
                    idx_n   = idx + IDX_W'(1);
                    state_n = last ? FINISH : ISSUE;
                end else if (rty < RTY_W'(RETRY_MAX)) begin
                    rty_n   = rty + RTY_W'(1);
                    state_n = ISSUE;
                end else begin
                    err_n   = 1'b1;
                    eidx_n  = idx;
                    state_n = FINISH;
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            num_q          <= '0;
            rty            <= '0;
            tmo            <= '0;
            nack_q         <= 1'b0;
            rdat_q         <= '0;
            bad            <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.rw         <= 1'b0;
            bus.slave_addr <= '0;
            bus.reg_addr   <= '0;
            bus.reg_data   <= '0;
            rd_valid       <= 1'b0;
            rd_idx         <= '0;
            rd_data        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_idx        <= '0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            num_q          <= num_n;
            rty            <= rty_n;
            tmo            <= tmo_n;
            nack_q         <= nack_n;
            rdat_q         <= rdat_n;
            bad            <= bad_n;
            bus.data_valid <= dv_n;
            bus.rw         <= rw_n;
            bus.slave_addr <= sa_n;
            bus.reg_addr   <= ra_n;
            bus.reg_data   <= rg_n;
            rd_valid       <= rdv_n;
            rd_idx         <= rdi_n;
            rd_data        <= rdd_n;
            busy           <= (state_n != IDLE);
            done           <= done_n;
            error          <= err_n;
            err_idx        <= eidx_n;
        end
    end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Directed bench for i2c_seq_ctrl: a scripted I2C core responder plus a
// table of whole-sequence vectors and a few hand-written corner sequences.
module tb_i2c_seq_ctrl;

    localparam int unsigned IDX_W    = 4;
    localparam int          BUSY_LEN = 3;
    localparam int          LIMIT    = 4000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W:0]   num_cmds = '0;
    logic             tbl_we = 1'b0;
    logic [IDX_W-1:0] tbl_idx = '0;
    logic [23:0]      tbl_wdata = '0;
    logic             rd_valid;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       rd_data;
    logic             busy, done, error;
    logic [IDX_W-1:0] err_idx;

    i2c_seq_ctrl_if bus();

    i2c_seq_ctrl #(.N_CMD(4), .RETRY_MAX(2), .TMO(255), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_cmds(num_cmds),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_wdata(tbl_wdata),
        .bus(bus),
        .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core script: per-issue NACK bits, a dead-core switch and the read byte.
    logic [7:0]  nack_mask = '0;
    logic        dead      = 1'b0;
    logic [7:0]  rdata_val = 8'hA5;
    int          issue_cnt = 0;
    logic [23:0] issue_log [16];
    int          issue_cyc [16];

    initial begin : core
        bus.core_busy  = 1'b0;
        bus.core_nack  = 1'b0;
        bus.core_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.data_valid === 1'b1) begin
                int n;
                n = issue_cnt;
                if (n < 16) begin
                    issue_log[n] = {bus.rw, bus.slave_addr, bus.reg_addr, bus.reg_data};
                    issue_cyc[n] = cyc;
                end
                issue_cnt = n + 1;
                if (!dead) begin
                    bus.core_busy = 1'b1;
                    bus.core_nack = 1'b0;
                    repeat (BUSY_LEN) @(negedge clk);
                    bus.core_nack  = (n < 8) ? nack_mask[n[2:0]] : 1'b0;
                    bus.core_rdata = rdata_val;
                    bus.core_busy  = 1'b0;
                end
            end
        end
    end

    // Read-strobe monitor and the no-issue-around-reset guard.
    int               rd_cnt = 0;
    logic [IDX_W-1:0] rd_last_idx = '0;
    logic [7:0]       rd_last_data = '0;
    logic             rst_s1 = 1'b0, rst_s2 = 1'b0;
    always @(posedge clk) begin
        rst_s1 <= rst;
        rst_s2 <= rst_s1;
    end
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            rd_cnt       = rd_cnt + 1;
            rd_last_idx  = rd_idx;
            rd_last_data = rd_data;
        end
        if ((rst_s1 || rst_s2) && bus.data_valid !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL dv_near_rst: data_valid=%b required 0 at cycle %0d", bus.data_valid, cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tbl_write(input logic [IDX_W-1:0] i, input logic [23:0] d);
        tbl_we = 1'b1; tbl_idx = i; tbl_wdata = d;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic run(input logic [IDX_W:0] n, output logic busy_at_start, output logic seen);
        issue_cnt = 0;
        rd_cnt    = 0;
        num_cmds  = n;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_at_start = busy;
        seen = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [IDX_W:0]  num;
        logic [7:0]      mask;
        logic            dead;
        logic [7:0]      rdata;
        int              n_iss;
        logic [15:0]     ents;     // 2-bit entry number of issue k at [2k+1:2k]
        logic            err;
        logic [IDX_W-1:0] eidx;
        int              n_rd;
        logic [IDX_W-1:0] rdidx;
        int              gap;      // issue0->issue1 cycle gap, 0 = unchecked
    } vec_t;

    logic [23:0] tbl_exp [4];
    vec_t        vecs [6];

    initial begin
        logic bs, seen;
        logic [1:0] e;
        int ni;

        tbl_exp[0] = 24'hE63233;   // {1,0x66,0x32,0x33}
        tbl_exp[1] = 24'hAE333C;   // {1,0x2E,0x33,0x3C}
        tbl_exp[2] = 24'h2E1000;   // {0,0x2E,0x10,--}
        tbl_exp[3] = 24'h502000;   // {0,0x50,0x20,--}

        vecs[0] = '{num:5'd3, mask:8'h00, dead:1'b0, rdata:8'hA5, n_iss:3, ents:16'h0024,
                    err:1'b0, eidx:4'd0, n_rd:1, rdidx:4'd2, gap:0};
        vecs[1] = '{num:5'd3, mask:8'h06, dead:1'b0, rdata:8'h3C, n_iss:5, ents:16'h0254,
                    err:1'b0, eidx:4'd0, n_rd:1, rdidx:4'd2, gap:0};
        vecs[2] = '{num:5'd3, mask:8'h07, dead:1'b0, rdata:8'hA5, n_iss:3, ents:16'h0000,
                    err:1'b1, eidx:4'd0, n_rd:0, rdidx:4'd0, gap:0};
        vecs[3] = '{num:5'd1, mask:8'h00, dead:1'b1, rdata:8'hA5, n_iss:3, ents:16'h0000,
                    err:1'b1, eidx:4'd0, n_rd:0, rdidx:4'd0, gap:257};
        vecs[4] = '{num:5'd4, mask:8'h08, dead:1'b0, rdata:8'h5A, n_iss:5, ents:16'h03E4,
                    err:1'b0, eidx:4'd0, n_rd:2, rdidx:4'd3, gap:0};
        vecs[5] = '{num:5'd3, mask:8'h1C, dead:1'b0, rdata:8'hA5, n_iss:5, ents:16'h02A4,
                    err:1'b1, eidx:4'd2, n_rd:0, rdidx:4'd0, gap:0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({busy, done, error, err_idx, bus.data_valid, rd_valid, rd_idx, rd_data,
                 bus.rw, bus.slave_addr}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) tbl_write(4'(i), tbl_exp[i]);

        // Out-of-range starts: done+error pulse together, busy stays low
        for (int k = 0; k < 2; k++) begin
            num_cmds = (k == 0) ? 5'd0 : 5'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("bad_start%0d.pulse", k), {29'd0, done, error, busy}, 32'b110);
            chk($sformatf("bad_start%0d.err_idx", k), 32'(err_idx), 32'd0);
            @(negedge clk);
            chk($sformatf("bad_start%0d.after", k), {29'd0, done, error, busy}, 32'b000);
        end

        // Whole-sequence vectors
        foreach (vecs[i]) begin
            nack_mask = vecs[i].mask;
            dead      = vecs[i].dead;
            rdata_val = vecs[i].rdata;
            run(vecs[i].num, bs, seen);
            chk($sformatf("v%0d.busy_start", i), 32'(bs), 32'd1);
            chk($sformatf("v%0d.done", i), 32'(seen), 32'd1);
            chk($sformatf("v%0d.busy_done", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d.error", i), 32'(error), 32'(vecs[i].err));
            chk($sformatf("v%0d.err_idx", i), 32'(err_idx), 32'(vecs[i].eidx));
            chk($sformatf("v%0d.issues", i), 32'(issue_cnt), 32'(vecs[i].n_iss));
            ni = (issue_cnt < vecs[i].n_iss) ? issue_cnt : vecs[i].n_iss;
            for (int k = 0; k < ni; k++) begin
                e = vecs[i].ents[2*k +: 2];
                chk($sformatf("v%0d.issue%0d", i, k), 32'(issue_log[k]), 32'(tbl_exp[e]));
            end
            chk($sformatf("v%0d.rd_cnt", i), 32'(rd_cnt), 32'(vecs[i].n_rd));
            if (vecs[i].n_rd > 0) begin
                chk($sformatf("v%0d.rd_idx", i), 32'(rd_last_idx), 32'(vecs[i].rdidx));
                chk($sformatf("v%0d.rd_data", i), 32'(rd_last_data), 32'(vecs[i].rdata));
            end
            if (vecs[i].gap > 0 && issue_cnt > 1)
                chk($sformatf("v%0d.tmo_gap", i), 32'(issue_cyc[1] - issue_cyc[0]), 32'(vecs[i].gap));
            @(negedge clk);
            chk($sformatf("v%0d.done_pulse", i), 32'(done), 32'd0);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d.err_hold", i), 32'(error), 32'(vecs[i].err));
        end
        nack_mask = '0;
        dead      = 1'b0;
        rdata_val = 8'hA5;

        // Table write while busy is ignored
        issue_cnt = 0;
        num_cmds  = 5'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tbl_write(4'd0, 24'hFFFFFF);
        seen = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("we_busy.done", 32'(seen), 32'd1);
        @(negedge clk);
        run(5'd1, bs, seen);
        chk("we_busy.issue0", 32'(issue_log[0]), 32'(tbl_exp[0]));

        // Reset while waiting for the core to finish, then restart
        @(negedge clk);
        issue_cnt = 0;
        num_cmds  = 5'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            if (bus.data_valid === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("rst_wlo.issued", 32'(seen), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wlo.outputs", {28'd0, busy, bus.data_valid, done, error}, 32'd0);
        repeat (6) @(negedge clk);
        run(5'd3, bs, seen);
        chk("rst_wlo.done", 32'(seen), 32'd1);
        chk("rst_wlo.issues", 32'(issue_cnt), 32'd3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("rst_wlo.issue%0d", k), 32'(issue_log[k]), 32'(tbl_exp[k]));
        chk("rst_wlo.error", 32'(error), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
